// File: rtl/esc_serial_arbiter_if.sv
// esc_serial_arbiter_if
// Byte-stream bundle between the two TX requesters, the ESC passthrough
// UART bridge and the two RX consumers.
//   pc_tx_*  : PC requester byte stream (valid/ready)
//   fw_tx_*  : 4-way interface handler byte stream (valid/ready)
//   br_tx_*  : byte stream into the bridge (valid/ready)
//   br_rx_*  : bytes received from the ESC (valid only, no back-pressure)
//   pc_rx_*  : RX bytes routed to the PC
//   fw_rx_*  : RX bytes routed to the 4-way handler
// Modports: slave = arbiter side, master = surrounding logic / bench.
interface esc_serial_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] pc_tx_data;
  logic              pc_tx_valid;
  logic              pc_tx_ready;
  logic [DATA_W-1:0] fw_tx_data;
  logic              fw_tx_valid;
  logic              fw_tx_ready;
  logic [DATA_W-1:0] br_tx_data;
  logic              br_tx_valid;
  logic              br_tx_ready;
  logic [DATA_W-1:0] br_rx_data;
  logic              br_rx_valid;
  logic [DATA_W-1:0] pc_rx_data;
  logic              pc_rx_valid;
  logic [DATA_W-1:0] fw_rx_data;
  logic              fw_rx_valid;

  modport slave (
    input  pc_tx_data, pc_tx_valid, fw_tx_data, fw_tx_valid,
    input  br_tx_ready, br_rx_data, br_rx_valid,
    output pc_tx_ready, fw_tx_ready, br_tx_data, br_tx_valid,
    output pc_rx_data, pc_rx_valid, fw_rx_data, fw_rx_valid
  );

  modport master (
    output pc_tx_data, pc_tx_valid, fw_tx_data, fw_tx_valid,
    output br_tx_ready, br_rx_data, br_rx_valid,
    input  pc_tx_ready, fw_tx_ready, br_tx_data, br_tx_valid,
    input  pc_rx_data, pc_rx_valid, fw_rx_data, fw_rx_valid
  );
endinterface

// File: rtl/esc_serial_arbiter.sv
// esc_serial_arbiter
// Shares the passthrough bridge's single TX byte port between the PC stream
// and the 4-way handler. Ownership is held for a whole transaction and
// dropped after IDLE_GAP_CYCLES cycles with neither a TX handshake nor an RX
// byte, so frames from the two sources never interleave. RX bytes follow the
// current owner (unsolicited bytes go to the PC). The ESC pad selection can
// only change while nobody owns the bridge.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_pt_enable      : global passthrough enable (0 forces release, pads off)
//   i_cfg_chan       : requested ESC channel
//   i_cfg_chan_wr    : channel write strobe
//   io_bus           : byte streams (see esc_serial_arbiter_if)
//   o_esc_chan       : active channel index
//   o_esc_pad_en     : one-hot pad enable, zero when passthrough is off
//   o_owner          : 0 none, 1 PC, 2 4-way
//   o_cfg_rejected   : one-cycle pulse after an ignored channel write
module esc_serial_arbiter #(
  parameter int CLK_FREQ_HZ     = 72_000_000,
  parameter int IDLE_GAP_CYCLES = 72_000,
  parameter int NUM_CHANNELS    = 4,
  localparam int CHAN_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_pt_enable,
  input  logic [CHAN_W-1:0]       i_cfg_chan,
  input  logic                    i_cfg_chan_wr,
  esc_serial_arbiter_if.slave     io_bus,
  output logic [CHAN_W-1:0]       o_esc_chan,
  output logic [NUM_CHANNELS-1:0] o_esc_pad_en,
  output logic [1:0]              o_owner,
  output logic                    o_cfg_rejected
);

  localparam int GAP_W = $clog2(IDLE_GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(IDLE_GAP_CYCLES - 1);
  localparam logic [CHAN_W:0]   CHAN_LIM = (CHAN_W + 1)'(NUM_CHANNELS);

  // A gap below 2 leaves no room for the counter to see an idle cycle.
  if (IDLE_GAP_CYCLES < 2 || CLK_FREQ_HZ <= 0) begin : g_bad_cfg
    $error("esc_serial_arbiter: IDLE_GAP_CYCLES must be >= 2");
  end

  // State encoding doubles as the owner code.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_PC = 2'd1,
    OWN_FW = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [GAP_W-1:0]    r_gap;
  logic [GAP_W-1:0]    w_gap_next;
  logic [CHAN_W-1:0]   r_chan;
  logic                r_cfg_rej;
  logic                w_activity;
  logic                w_chan_ok;
  logic                w_chan_accept;
  logic [NUM_CHANNELS-1:0] w_pad_en;

  // State and gap counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= w_gap_next;
    end
  end

  // Next-state, gap counter and handshake muxing
  always_comb begin
    w_state_next         = r_state;
    w_gap_next           = r_gap;
    w_activity           = 1'b0;
    io_bus.pc_tx_ready   = 1'b0;
    io_bus.fw_tx_ready   = 1'b0;
    io_bus.br_tx_valid   = 1'b0;
    io_bus.br_tx_data    = io_bus.pc_tx_data;
    io_bus.pc_rx_valid   = 1'b0;
    io_bus.fw_rx_valid   = 1'b0;
    io_bus.pc_rx_data    = io_bus.br_rx_data;
    io_bus.fw_rx_data    = io_bus.br_rx_data;

    if (!i_pt_enable) begin
      w_state_next = IDLE;
      w_gap_next   = '0;
    end else begin
      // Unowned RX bytes are unsolicited and belong to the PC.
      io_bus.pc_rx_valid = io_bus.br_rx_valid && (r_state != OWN_FW);
      io_bus.fw_rx_valid = io_bus.br_rx_valid && (r_state == OWN_FW);

      case (r_state)
        IDLE: begin
          w_gap_next = '0;
          // The 4-way handler wins ties.
          if (io_bus.fw_tx_valid)      w_state_next = OWN_FW;
          else if (io_bus.pc_tx_valid) w_state_next = OWN_PC;
        end
        OWN_PC, OWN_FW: begin
          if (r_state == OWN_FW) begin
            io_bus.br_tx_data  = io_bus.fw_tx_data;
            io_bus.br_tx_valid = io_bus.fw_tx_valid;
            io_bus.fw_tx_ready = io_bus.br_tx_ready;
          end else begin
            io_bus.br_tx_data  = io_bus.pc_tx_data;
            io_bus.br_tx_valid = io_bus.pc_tx_valid;
            io_bus.pc_tx_ready = io_bus.br_tx_ready;
          end
          w_activity = (io_bus.br_tx_valid && io_bus.br_tx_ready) ||
                       io_bus.br_rx_valid;
          if (w_activity) begin
            w_gap_next = '0;
          end else if (r_gap == GAP_LAST) begin
            w_state_next = IDLE;
            w_gap_next   = '0;
          end else if (r_gap != '1) begin
            w_gap_next = r_gap + 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_gap_next   = '0;
        end
      endcase
    end
  end

  // Channel select: only changes while the bridge is unowned.
  assign w_chan_ok     = {1'b0, i_cfg_chan} < CHAN_LIM;
  assign w_chan_accept = i_cfg_chan_wr && (r_state == IDLE) && w_chan_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan    <= '0;
      r_cfg_rej <= 1'b0;
    end else begin
      if (w_chan_accept) r_chan <= i_cfg_chan;
      r_cfg_rej <= i_cfg_chan_wr && !w_chan_accept;
    end
  end

  always_comb begin
    w_pad_en = '0;
    if (i_pt_enable) w_pad_en[r_chan] = 1'b1;
  end

  assign o_esc_chan     = r_chan;
  assign o_esc_pad_en   = w_pad_en;
  assign o_owner        = r_state;
  assign o_cfg_rejected = r_cfg_rej;

endmodule

// File: tb/tb_esc_serial_arbiter.sv
// tb_esc_serial_arbiter
// Directed bench for esc_serial_arbiter with an 8-cycle idle gap. A second
// instance with five channels exercises the out-of-range channel write.
module tb_esc_serial_arbiter;

  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       pt_en;
  logic [1:0] cfg_chan;
  logic       cfg_wr;
  logic [1:0] esc_chan;
  logic [3:0] pad_en;
  logic [1:0] owner;
  logic       cfg_rej;

  logic       pt_en2;
  logic [2:0] cfg_chan2;
  logic       cfg_wr2;
  logic [2:0] esc_chan2;
  logic [4:0] pad_en2;
  logic [1:0] owner2;
  logic       cfg_rej2;

  int total = 0;
  int bad   = 0;

  esc_serial_arbiter_if bus ();
  esc_serial_arbiter_if bus2 ();

  esc_serial_arbiter #(
    .CLK_FREQ_HZ(72_000_000), .IDLE_GAP_CYCLES(GAP), .NUM_CHANNELS(4)
  ) dut (
    .clk(clk), .rst(rst), .i_pt_enable(pt_en), .i_cfg_chan(cfg_chan),
    .i_cfg_chan_wr(cfg_wr), .io_bus(bus.slave), .o_esc_chan(esc_chan),
    .o_esc_pad_en(pad_en), .o_owner(owner), .o_cfg_rejected(cfg_rej)
  );

  esc_serial_arbiter #(
    .CLK_FREQ_HZ(72_000_000), .IDLE_GAP_CYCLES(GAP), .NUM_CHANNELS(5)
  ) dut2 (
    .clk(clk), .rst(rst), .i_pt_enable(pt_en2), .i_cfg_chan(cfg_chan2),
    .i_cfg_chan_wr(cfg_wr2), .io_bus(bus2.slave), .o_esc_chan(esc_chan2),
    .o_esc_pad_en(pad_en2), .o_owner(owner2), .o_cfg_rejected(cfg_rej2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pt_en = 1'b0; cfg_chan = '0; cfg_wr = 1'b0;
    pt_en2 = 1'b0; cfg_chan2 = '0; cfg_wr2 = 1'b0;
    bus.pc_tx_data = '0; bus.pc_tx_valid = 1'b0;
    bus.fw_tx_data = '0; bus.fw_tx_valid = 1'b0;
    bus.br_tx_ready = 1'b0; bus.br_rx_data = '0; bus.br_rx_valid = 1'b0;
    bus2.pc_tx_data = '0; bus2.pc_tx_valid = 1'b0;
    bus2.fw_tx_data = '0; bus2.fw_tx_valid = 1'b0;
    bus2.br_tx_ready = 1'b0; bus2.br_rx_data = '0; bus2.br_rx_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_owner",   32'(owner), 32'd0);
    chk("rst_chan",    32'(esc_chan), 32'd0);
    chk("rst_rej",     32'(cfg_rej), 32'd0);
    chk("rst_pad",     32'(pad_en), 32'd0);
    chk("rst_pc_rdy",  32'(bus.pc_tx_ready), 32'd0);
    chk("rst_fw_rdy",  32'(bus.fw_tx_ready), 32'd0);
    chk("rst_br_vld",  32'(bus.br_tx_valid), 32'd0);
    chk("rst_pc_rx",   32'(bus.pc_rx_valid), 32'd0);

    // Enable, no requests
    rst = 1'b0; pt_en = 1'b1; pt_en2 = 1'b1;
    #1;
    chk("en_pad", 32'(pad_en), 32'h1);
    tick();
    chk("en_owner",  32'(owner), 32'd0);
    chk("en_pc_rdy", 32'(bus.pc_tx_ready), 32'd0);
    chk("en_fw_rdy", 32'(bus.fw_tx_ready), 32'd0);

    // Channel 2 written in IDLE
    cfg_chan = 2'd2; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("ch2_chan", 32'(esc_chan), 32'd2);
    chk("ch2_pad",  32'(pad_en), 32'h4);
    chk("ch2_rej",  32'(cfg_rej), 32'd0);

    // Out-of-range channel on the five-pad instance, then a valid one
    cfg_chan2 = 3'd5; cfg_wr2 = 1'b1;
    tick();
    cfg_wr2 = 1'b0;
    chk("ch5_rej",  32'(cfg_rej2), 32'd1);
    chk("ch5_chan", 32'(esc_chan2), 32'd0);
    cfg_chan2 = 3'd4; cfg_wr2 = 1'b1;
    tick();
    cfg_wr2 = 1'b0;
    chk("ch4_rej",  32'(cfg_rej2), 32'd0);
    chk("ch4_chan", 32'(esc_chan2), 32'd4);
    chk("ch4_pad",  32'(pad_en2), 32'h10);

    // Simultaneous requests: 4-way wins
    bus.pc_tx_data = 8'hA1; bus.pc_tx_valid = 1'b1;
    bus.fw_tx_data = 8'h2F; bus.fw_tx_valid = 1'b1;
    bus.br_tx_ready = 1'b0;
    #1;
    chk("idle_fw_rdy", 32'(bus.fw_tx_ready), 32'd0);
    chk("idle_pc_rdy", 32'(bus.pc_tx_ready), 32'd0);
    chk("idle_br_vld", 32'(bus.br_tx_valid), 32'd0);
    tick();
    chk("tie_owner",  32'(owner), 32'd2);
    chk("tie_br_vld", 32'(bus.br_tx_valid), 32'd1);
    chk("tie_br_d0",  32'(bus.br_tx_data), 32'h2F);
    chk("tie_fw_rdy0", 32'(bus.fw_tx_ready), 32'd0);
    bus.br_tx_ready = 1'b1;
    #1;
    chk("tie_fw_rdy1", 32'(bus.fw_tx_ready), 32'd1);
    chk("tie_pc_rdy",  32'(bus.pc_tx_ready), 32'd0);
    tick();
    bus.fw_tx_data = 8'h3A;
    #1;
    chk("tie_br_d1", 32'(bus.br_tx_data), 32'h3A);
    tick();
    bus.fw_tx_valid = 1'b0;
    repeat (GAP - 1) tick();
    chk("fw_hold_owner", 32'(owner), 32'd2);
    chk("fw_hold_pc_rdy", 32'(bus.pc_tx_ready), 32'd0);
    tick();
    chk("fw_rel_owner", 32'(owner), 32'd0);
    chk("fw_rel_pc_rdy", 32'(bus.pc_tx_ready), 32'd0);
    tick();
    chk("pc_grant_owner", 32'(owner), 32'd1);
    chk("pc_grant_rdy",   32'(bus.pc_tx_ready), 32'd1);
    chk("pc_grant_data",  32'(bus.br_tx_data), 32'hA1);
    tick();
    bus.pc_tx_valid = 1'b0;

    // Gap boundary: RX byte at counter 7 keeps ownership
    repeat (GAP - 1) tick();
    chk("gap7_owner", 32'(owner), 32'd1);
    bus.br_rx_data = 8'h44; bus.br_rx_valid = 1'b1;
    #1;
    chk("gap7_pc_rx", 32'(bus.pc_rx_valid), 32'd1);
    chk("gap7_fw_rx", 32'(bus.fw_rx_valid), 32'd0);
    chk("gap7_pc_rxd", 32'(bus.pc_rx_data), 32'h44);
    tick();
    bus.br_rx_valid = 1'b0;
    chk("gap_keep_owner", 32'(owner), 32'd1);

    // Channel write while owned is rejected
    cfg_chan = 2'd3; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("busy_rej",  32'(cfg_rej), 32'd1);
    chk("busy_chan", 32'(esc_chan), 32'd2);
    tick();
    chk("busy_rej_end", 32'(cfg_rej), 32'd0);
    repeat (5) tick();
    chk("pc_hold_owner", 32'(owner), 32'd1);
    tick();
    chk("pc_rel_owner", 32'(owner), 32'd0);

    // Unowned RX goes to PC
    bus.br_rx_data = 8'h55; bus.br_rx_valid = 1'b1;
    #1;
    chk("none_pc_rx",  32'(bus.pc_rx_valid), 32'd1);
    chk("none_fw_rx",  32'(bus.fw_rx_valid), 32'd0);
    chk("none_pc_rxd", 32'(bus.pc_rx_data), 32'h55);
    tick();
    bus.br_rx_valid = 1'b0;

    // RX with 4-way owner
    bus.fw_tx_data = 8'h11; bus.fw_tx_valid = 1'b1; bus.br_tx_ready = 1'b0;
    tick();
    chk("fw2_owner", 32'(owner), 32'd2);
    bus.br_rx_data = 8'h30; bus.br_rx_valid = 1'b1;
    #1;
    chk("fw2_fw_rx",  32'(bus.fw_rx_valid), 32'd1);
    chk("fw2_pc_rx",  32'(bus.pc_rx_valid), 32'd0);
    chk("fw2_fw_rxd", 32'(bus.fw_rx_data), 32'h30);
    tick();
    bus.br_rx_valid = 1'b0; bus.fw_tx_valid = 1'b0;
    repeat (GAP - 1) tick();
    chk("fw2_hold_owner", 32'(owner), 32'd2);
    tick();
    chk("fw2_rel_owner", 32'(owner), 32'd0);

    // Passthrough dropped mid-transaction
    bus.pc_tx_data = 8'h77; bus.pc_tx_valid = 1'b1;
    tick();
    chk("drop_owner0", 32'(owner), 32'd1);
    bus.br_tx_ready = 1'b1;
    #1;
    chk("drop_pc_rdy0", 32'(bus.pc_tx_ready), 32'd1);
    pt_en = 1'b0; bus.br_rx_valid = 1'b1;
    #1;
    chk("drop_pc_rdy", 32'(bus.pc_tx_ready), 32'd0);
    chk("drop_br_vld", 32'(bus.br_tx_valid), 32'd0);
    chk("drop_pad",    32'(pad_en), 32'd0);
    chk("drop_pc_rx",  32'(bus.pc_rx_valid), 32'd0);
    chk("drop_fw_rx",  32'(bus.fw_rx_valid), 32'd0);
    tick();
    chk("drop_owner1", 32'(owner), 32'd0);
    chk("drop_pc_rdy1", 32'(bus.pc_tx_ready), 32'd0);
    chk("drop_pad1",   32'(pad_en), 32'd0);
    tick();
    chk("drop_owner2", 32'(owner), 32'd0);

    // Re-enable: pad restored, held PC request granted
    pt_en = 1'b1; bus.br_rx_valid = 1'b0;
    #1;
    chk("reen_pad", 32'(pad_en), 32'h4);
    tick();
    chk("reen_owner", 32'(owner), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/esc_serial_arbiter.md
# esc_serial_arbiter

Packet-level arbiter and channel controller in front of the ESC passthrough UART bridge. It shares the bridge's single byte-wide serial transmit port between two requesters, the PC byte stream and the 4-way interface handler. Ownership is held for a whole transaction and released after a configurable idle gap, so frames from the two sources never interleave. Receive bytes from the ESC are routed back to the current owner. It also selects which motor pad (ESC channel) the bridge is wired to and holds that selection fixed while a transaction is open.

## Interface
- CLK_FREQ_HZ, 72_000_000: system clock frequency (documentation only).
- IDLE_GAP_CYCLES, 72_000: idle cycles (1 ms) with no TX handshake and no RX byte before ownership is released. Must be ≥ 2.
- NUM_CHANNELS, 4: number of ESC pads. CHAN_W = $clog2(NUM_CHANNELS).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pt_enable  in  1  global passthrough enable.
- cfg_chan  in  CHAN_W  requested ESC channel.
- cfg_chan_wr  in  1  channel write strobe.
- pc_tx_data / pc_tx_valid  in  8 / 1  PC requester byte.
- pc_tx_ready  out  1  PC byte accepted.
- fw_tx_data / fw_tx_valid  in  8 / 1  4-way requester byte.
- fw_tx_ready  out  1  4-way byte accepted.
- br_tx_data / br_tx_valid  out  8 / 1  byte to bridge.
- br_tx_ready  in  1  bridge accepts byte.
- br_rx_data / br_rx_valid  in  8 / 1  byte received from ESC.
- pc_rx_data / pc_rx_valid  out  8 / 1  RX byte to PC.
- fw_rx_data / fw_rx_valid  out  8 / 1  RX byte to 4-way handler.
- esc_chan  out  CHAN_W  active channel index.
- esc_pad_en  out  NUM_CHANNELS  one-hot pad enable. All zeros when pt_enable=0.
- owner  out  2  0 = none, 1 = PC, 2 = 4-way.
- cfg_rejected  out  1  one-cycle pulse when a channel write is ignored.

## Operation
- States: IDLE, OWN_PC, OWN_FW.
- IDLE with pt_enable=1:
  - fw_tx_valid → OWN_FW. The 4-way handler wins ties.
  - Otherwise pc_tx_valid → OWN_PC.
  - No ready is asserted in IDLE.
- OWN_x:
  - br_tx_data/br_tx_valid mux from the owner. The owner's ready equals br_tx_ready. The other requester's ready is 0.
  - The gap counter clears on a TX handshake (owner valid & br_tx_ready) or on br_rx_valid, and otherwise increments.
  - When the counter is at IDLE_GAP_CYCLES-1 and does not clear, the next state is IDLE.
- pt_enable=0 in any state:
  - Next state is IDLE, counter cleared, esc_pad_en=0, no grants.
  - A byte already accepted by the bridge completes on the wire; this is outside this block's scope.
- RX routing:
  - br_rx_data is fanned out to both rx_data outputs.
  - pc_rx_valid = br_rx_valid when owner is PC or none (unsolicited bytes go to PC).
  - fw_rx_valid = br_rx_valid only when owner is 4-way.
  - RX valids are forced to 0 when pt_enable=0.
- Channel:
  - A cfg_chan_wr accepted in IDLE updates esc_chan next cycle.
  - A write while owner≠none is ignored and pulses cfg_rejected next cycle.
  - cfg_chan ≥ NUM_CHANNELS is ignored and pulses cfg_rejected.
  - esc_pad_en = one-hot(esc_chan) when pt_enable=1.

## Timing
- Reset values: state IDLE, owner=0, esc_chan=0, gap counter 0, cfg_rejected=0. All valids, readies and esc_pad_en are 0.
- Grant latency: a request seen in IDLE at cycle N gives owner and ready at N+1. The first byte can therefore transfer at N+1 at the earliest.
- The data/valid/ready path is combinational once granted (zero added latency). There is no buffering.
- Release: the last activity is at cycle N; owner=0 at N+IDLE_GAP_CYCLES. A new grant is possible at N+IDLE_GAP_CYCLES+1.
- Activity on the same cycle the counter would expire clears the counter; ownership is kept.
- A request from the non-owner is held off (ready=0) until release. Requesters must hold valid/data stable until ready.
- The gap counter width is $clog2(IDLE_GAP_CYCLES) and saturates; it never wraps.

## Test plan
- Reset, then pt_enable=1 with no requests: owner=0, all readies 0, esc_pad_en=4'b0001.
- pc_tx_valid and fw_tx_valid both asserted at cycle 10: owner=2 at cycle 11, fw bytes 0x2F, 0x3A reach br_tx_data, pc_tx_ready stays 0. PC is granted IDLE_GAP_CYCLES+1 cycles after the last FW byte.
- Gap boundary with IDLE_GAP_CYCLES=8: a br_rx_valid pulse at counter=7 keeps owner=1. With no activity, owner=0 exactly 8 cycles after the last event.
- Channel writes:
  - cfg_chan=2 written in IDLE: esc_chan=2, esc_pad_en=4'b0100 next cycle.
  - cfg_chan=3 written while owner=1: cfg_rejected pulses, esc_chan stays 2.
  - cfg_chan=5: rejected.
- RX routing: with owner=2, br_rx_valid carrying 0x30 reaches fw_rx_valid only. With owner=0, 0x55 reaches pc_rx_valid only.
- pt_enable dropped mid-transaction with owner=1: next cycle owner=0, pc_tx_ready=0, esc_pad_en=0, RX valids suppressed.
